ex_muldiv_sequencer: RTL and testbench

//  Multi-cycle RV32M multiply/divide sequencer beside the execute stage.
//  - Accepts one MUL/DIV op from execute and runs an iterative shift-add or restoring-divide datapath.
//  - Holds execute's ready_go low until the result is delivered.
//  - Is killed by a branch-mispredict flush.

---
 rtl/ex_muldiv_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer
//   Multi-cycle RV32M multiply/divide unit sitting beside the execute stage. It accepts one
//   M-extension op, runs an iterative shift-add multiply or restoring divide (one bit per
//   cycle), and holds execute's ready_go low until the result is handed to memory.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_op, i_req_src1, i_req_src2   request from execute
//   i_flush           mispredict kill, aborts anything in flight, wins over a new request
//   o_resp_valid/i_resp_ready, o_resp_data                        result towards memory
//   o_busy            sequencer not idle
//   o_ex_ready_go     ready_go to execute
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, all multiplies finish in one cycle through a
//                       combinational XLEN x XLEN multiplier; divides stay iterative.
module ex_muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_src1,
  input  logic [XLEN-1:0] i_req_src2,
  input  logic            i_flush,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_data,
  output logic            o_busy,
  output logic            o_ex_ready_go
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_mcand;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_acc;       // {hi, lo} product or {rem, quot}
  logic              r_neg_q;     // negate product / quotient at the end
  logic              r_neg_r;     // negate remainder at the end
  logic [XLEN-1:0]   r_resp_data;
  logic              r_resp_valid;
  logic              r_req_ready;
  logic              r_busy;

  // Accept-time decode
  logic              w_is_div;
  logic              w_s1;
  logic              w_s2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_res;

  assign w_is_div = i_req_op[2];
  assign w_s1     = (i_req_op == OpMul) || (i_req_op == OpMulh) || (i_req_op == OpMulhsu) ||
                    (i_req_op == OpDiv) || (i_req_op == OpRem);
  assign w_s2     = (i_req_op == OpMul) || (i_req_op == OpMulh) ||
                    (i_req_op == OpDiv) || (i_req_op == OpRem);
  assign w_neg1   = w_s1 && i_req_src1[XLEN-1];
  assign w_neg2   = w_s2 && i_req_src2[XLEN-1];
  assign w_mag1   = w_neg1 ? -i_req_src1 : i_req_src1;
  assign w_mag2   = w_neg2 ? -i_req_src2 : i_req_src2;
  assign w_div0   = w_is_div && (i_req_src2 == '0);
  assign w_ovf    = ((i_req_op == OpDiv) || (i_req_op == OpRem)) &&
                    (i_req_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_req_src2 == '1);

  // op[1] clear selects the quotient forms (DIV/DIVU), set selects the remainder forms
  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = i_req_op[1] ? i_req_src1 : '1;
    end else if (w_ovf) begin
      w_special_res = i_req_op[1] ? '0 : i_req_src1;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  logic [2*XLEN-1:0] w_fast_sprod;
  logic [XLEN-1:0]   w_fast_res;

  assign w_fast_prod  = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
  assign w_fast_sprod = (w_neg1 ^ w_neg2) ? -w_fast_prod : w_fast_prod;
  assign w_fast_res   = (i_req_op == OpMul) ? w_fast_sprod[XLEN-1:0]
                                            : w_fast_sprod[2*XLEN-1:XLEN];
`endif

  // One iteration of the shift-add multiplier: add multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole {carry, hi, lo} right by one.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // One iteration of the restoring divider on {rem, quot}. The shifted remainder needs one
  // extra bit; when it is >= divisor the difference always fits back into XLEN bits.
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;

  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge      = w_rem_sh >= {1'b0, r_mcand};
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_mcand;
  assign w_div_nxt = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

  // Final result from the last iteration, with the sign fix-up applied
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_calc_res;

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quot = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_calc_res = '0;
    unique case (r_op)
      3'd0:             w_calc_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_calc_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_calc_res = w_quot;
      default:          w_calc_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_op         <= '0;
      r_mcand      <= '0;
      r_acc        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_resp_data  <= '0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid && r_req_ready && !i_flush) begin
            r_op    <= i_req_op;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            if (w_div0 || w_ovf) begin
              r_resp_data  <= w_special_res;
              r_resp_valid <= 1'b1;
              r_state      <= StDone;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!w_is_div) begin
              r_resp_data  <= w_fast_res;
              r_resp_valid <= 1'b1;
              r_state      <= StDone;
`endif
            end else begin
              r_cnt   <= '0;
              r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
              r_mcand <= w_is_div ? w_mag2 : w_mag1;
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          if (i_flush) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end else if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_acc        <= w_acc_nxt;
            r_cnt        <= '0;
            r_resp_data  <= w_calc_res;
            r_resp_valid <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StDone: begin
          // A flush here discards the result even if memory accepts it this cycle
          if (i_flush || i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= StIdle;
        end
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_data   = r_resp_data;
  assign o_busy        = r_busy;
  assign o_ex_ready_go = ((r_state == StIdle) && !i_req_valid) || (r_resp_valid && i_resp_ready);

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            i_req_valid;
  logic            o_req_ready;
  logic [2:0]      i_req_op;
  logic [XLEN-1:0] i_req_src1;
  logic [XLEN-1:0] i_req_src2;
  logic            i_flush;
  logic            o_resp_valid;
  logic            i_resp_ready;
  logic [XLEN-1:0] o_resp_data;
  logic            o_busy;
  logic            o_ex_ready_go;

  ex_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (i_req_op),
    .i_req_src1   (i_req_src1),
    .i_req_src2   (i_req_src2),
    .i_flush      (i_flush),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_data  (o_resp_data),
    .o_busy       (o_busy),
    .o_ex_ready_go(o_ex_ready_go)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t scb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    logic signed [31:0] r;
    qa = a;
    qb = b;
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = qa / qb;
        return r;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = qa % qb;
        return r;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Latency in the form T+k, where T is the accept cycle
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic [2:0] o;
    o = op;
    if (o[2] && b == 32'd0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Present one request at the current (post-edge) time and step through the accept edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int   n;
    exp_t e;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_req_ready) begin
      failures++;
      $display("FAIL issue_ready_timeout req_ready=%0b required=1", o_req_ready);
    end
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_src1  = a;
    i_req_src2  = b;
    e.data = model(op, a, b);
    e.lat  = exp_lat(op, a, b);
    scb.push_back(e);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_req_src1  = $urandom;
    i_req_src2  = $urandom;
  endtask

  // Wait (bounded) for the response and compare it against the scoreboard head
  task automatic collect(input string name, output logic [31:0] got);
    int   lat;
    exp_t e;
    lat = 1;
    while (!o_resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e   = scb.pop_front();
    got = o_resp_data;
    checks++;
    if (o_resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout resp_valid=%0b required=1", name, o_resp_valid);
    end else begin
      checks++;
      if (o_resp_data !== e.data) begin
        failures++;
        $display("FAIL %s_data got=%08h required=%08h", name, o_resp_data, e.data);
      end
      checks++;
      if (lat != e.lat) begin
        failures++;
        $display("FAIL %s_latency got=T+%0d required=T+%0d", name, lat, e.lat);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] got;
    issue(op, a, b);
    collect(name, got);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%0b valid=%0b busy=%0b required 1/0/0",
               o_req_ready, o_resp_valid, o_busy);
    end
    checks++;
    if (o_resp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%08h required=00000000", o_resp_data);
    end
    checks++;
    if (o_ex_ready_go !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_go got=%0b required=1", o_ex_ready_go);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    if (scb[0].lat > 1) begin
      checks++;
      if (o_busy !== 1'b1 || o_req_ready !== 1'b0 || o_ex_ready_go !== 1'b0) begin
        failures++;
        $display("FAIL mul_calc_flags got busy=%0b ready=%0b go=%0b required 1/0/0",
                 o_busy, o_req_ready, o_ex_ready_go);
      end
    end
    begin
      logic [31:0] got;
      collect("mul_7x-3", got);
    end
    run_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 4; i++) begin
      run_op("mul_rand", 3'(i), $urandom, $urandom);
    end
  endtask

  task automatic test_div;
    run_op("div_-20_3", 3'd4, 32'hFFFF_FFEC, 32'd3);
    run_op("rem_-20_3", 3'd6, 32'hFFFF_FFEC, 32'd3);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("rem_20_-3", 3'd6, 32'd20, 32'hFFFF_FFFD);
    for (int i = 0; i < 4; i++) begin
      run_op("div_rand", 3'(4 + i), $urandom, $urandom | 32'd1);
    end
  endtask

  task automatic test_special;
    run_op("div_by0", 3'd4, 32'd1234, 32'd0);
    run_op("divu_by0", 3'd5, 32'hDEAD_BEEF, 32'd0);
    run_op("rem_5_by0", 3'd6, 32'd5, 32'd0);
    run_op("remu_by0", 3'd7, 32'hCAFE_F00D, 32'd0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_flush;
    logic seen;
    logic [31:0] got;
    exp_t e;
    seen = 1'b0;
    // Now in T+1 after the accept edge; advance to T+10
    issue(3'd4, 32'd1000, 32'd7);
    void'(scb.pop_front());
    repeat (9) begin
      @(posedge clk); #1;
      seen = seen | o_resp_valid;
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    seen = seen | o_resp_valid;
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc got busy=%0b resp_seen=%0b required 0/0", o_busy, seen);
    end
    // New request in T+11 must be accepted on the next edge
    i_req_valid = 1'b1;
    i_req_op    = 3'd5;
    i_req_src1  = 32'd100;
    i_req_src2  = 32'd7;
    e.data = 32'd14;
    e.lat  = XLEN + 1;
    scb.push_back(e);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_reaccept got busy=%0b required=1", o_busy);
    end
    collect("flush_next_divu", got);
    // Flush together with a request in IDLE: request is dropped
    i_req_valid = 1'b1;
    i_flush     = 1'b1;
    i_req_op    = 3'd0;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_flush     = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_with_req got busy=%0b ready=%0b required 0/1", o_busy, o_req_ready);
    end
    // Flush in DONE together with resp_ready: result discarded
    i_resp_ready = 1'b0;
    run_op("flush_done_op", 3'd4, 32'd9, 32'd0);
    i_flush      = 1'b1;
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    checks++;
    if (o_resp_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_done got valid=%0b busy=%0b required 0/0", o_resp_valid, o_busy);
    end
  endtask

  task automatic test_hold;
    logic [31:0] got;
    i_resp_ready = 1'b0;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    collect("hold_mul", got);
    // Junk request while in DONE must be ignored
    i_req_valid = 1'b1;
    i_req_op    = 3'd4;
    i_req_src1  = 32'd1;
    i_req_src2  = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_resp_valid !== 1'b1 || o_resp_data !== 32'hFFFF_FFEB || o_ex_ready_go !== 1'b0 ||
          o_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable got valid=%0b data=%08h go=%0b ready=%0b required 1/ffffffeb/0/0",
                 o_resp_valid, o_resp_data, o_ex_ready_go, o_req_ready);
      end
    end
    i_req_valid  = 1'b0;
    i_resp_ready = 1'b1;
    #1;
    checks++;
    if (o_ex_ready_go !== 1'b1) begin
      failures++;
      $display("FAIL hold_release_go got=%0b required=1", o_ex_ready_go);
    end
    @(posedge clk); #1;
    checks++;
    if (o_resp_valid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_retire got valid=%0b busy=%0b ready=%0b required 0/0/1",
               o_resp_valid, o_busy, o_req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    exp_t e;
    issue(3'd5, 32'd77, 32'd0);
    collect("b2b_first", got);
    // DONE retires at this edge; the request offered now must not be taken yet
    i_req_valid = 1'b1;
    i_req_op    = 3'd7;
    i_req_src1  = 32'd42;
    i_req_src2  = 32'd0;
    e.data = 32'd42;
    e.lat  = 1;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap got busy=%0b ready=%0b required 0/1", o_busy, o_req_ready);
    end
    scb.push_back(e);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    collect("b2b_second", got);
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    issue(3'd4, 32'd5000, 32'd3);
    void'(scb.pop_front());
    repeat (5) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_resp_valid !== 1'b0 || o_req_ready !== 1'b1 ||
        o_resp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%0b valid=%0b ready=%0b data=%08h required 0/0/1/0",
               o_busy, o_resp_valid, o_req_ready, o_resp_data);
    end
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | o_resp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_partial resp_valid_seen=%0b required=0", seen);
    end
  endtask

  initial begin
    rst          = 1'b1;
    i_req_valid  = 1'b0;
    i_req_op     = 3'd0;
    i_req_src1   = '0;
    i_req_src2   = '0;
    i_flush      = 1'b0;
    i_resp_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
